// File: rtl/cmd_script_seq.sv
// cmd_script_seq: move-script player for RemoteComm.
// It holds DEPTH 16-bit Knight commands and issues the first len of them in
// order. For each command it waits for an 8-bit response, compares it with
// ACK, and applies a per-command timeout of TIMEOUT_CYC clocks.
// Optional feature macro: SCRIPT_LOOP_EN adds loop_i. When loop_i is high at
// the last entry, the player wraps back to entry 0 instead of finishing.
module cmd_script_seq #(
  parameter int         DEPTH       = 8,
  parameter int         TIMEOUT_CYC = 10000000,
  parameter logic [7:0] ACK         = 8'hA5,
  localparam int        AW          = $clog2(DEPTH),
  localparam int        LW          = AW + 1,
  localparam int        TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [LW-1:0] len_i,
  input  logic          start_i,
  input  logic          abort_i,
`ifdef SCRIPT_LOOP_EN
  input  logic          loop_i,
`endif
  output logic [15:0]   cmd_o,
  output logic          send_cmd_o,
  input  logic          cmd_sent_i,
  input  logic          resp_rdy_i,
  input  logic [7:0]    resp_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o,
  output logic [AW-1:0] err_idx_o,
  output logic [AW-1:0] cur_idx_o
);

  // state       | meaning
  // S_IDLE      | waiting for start; script memory writable
  // S_LOAD      | fetch mem[cur_idx] into the command register
  // S_SEND      | one-cycle send_cmd strobe; arm the timeout
  // S_WAIT_SENT | waiting for cmd_sent (a response here is also accepted)
  // S_WAIT_RESP | waiting for resp_rdy
  // S_DONE      | one-cycle done pulse, then back to idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_BADRESP = 2'b10;
  localparam logic [1:0] E_ABORT   = 2'b11;

  state_t        state_q;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   cmd_q;
  logic          send_cmd_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [AW-1:0] err_idx_q;
  logic [AW-1:0] cur_idx_q;
  logic [LW-1:0] len_q;
  logic [TW-1:0] tmr_q;

  logic [LW-1:0] len_d;
  logic          last_entry;
  logic          resp_ok;
  logic          tmr_expired;
  logic          loop_en;

  // A length above DEPTH plays the whole script.
  assign len_d       = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
  assign last_entry  = ({1'b0, cur_idx_q} == (len_q - LW'(1)));
  assign resp_ok     = (resp_i == ACK);
  assign tmr_expired = (tmr_q == '0);

`ifdef SCRIPT_LOOP_EN
  assign loop_en = loop_i;
`else
  assign loop_en = 1'b0;
`endif

  // Script memory: host writes are allowed only while no playback is in progress.
  always_ff @(posedge clk) begin
    if (wr_en_i && !busy_q) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Playback FSM with registered outputs. The timeout is a down-counter
  // loaded in SEND, so it reaches zero on the TIMEOUT_CYC-th wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      send_cmd_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
      err_idx_q  <= '0;
      cur_idx_q  <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
    end else begin
      send_cmd_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
            err_idx_q  <= '0;
            cur_idx_q  <= '0;
            len_q      <= len_d;
            busy_q     <= 1'b1;
            if (len_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= E_ABORT;
            err_idx_q  <= cur_idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cmd_q      <= mem_q[cur_idx_q];
            send_cmd_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end

        S_SEND: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= E_ABORT;
            err_idx_q  <= cur_idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tmr_q   <= TW'(TIMEOUT_CYC - 1);
            state_q <= S_WAIT_SENT;
          end
        end

        S_WAIT_SENT, S_WAIT_RESP: begin
          if (abort_i) begin
            err_q      <= 1'b1;
            err_code_q <= E_ABORT;
            err_idx_q  <= cur_idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else if (resp_rdy_i) begin
            // A response at the timeout limit still counts.
            if (!resp_ok) begin
              err_q      <= 1'b1;
              err_code_q <= E_BADRESP;
              err_idx_q  <= cur_idx_q;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else if (!last_entry) begin
              cur_idx_q <= cur_idx_q + AW'(1);
              state_q   <= S_LOAD;
            end else if (loop_en) begin
              cur_idx_q <= '0;
              state_q   <= S_LOAD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (tmr_expired) begin
            err_q      <= 1'b1;
            err_code_q <= E_TIMEOUT;
            err_idx_q  <= cur_idx_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
            if (state_q == S_WAIT_SENT && cmd_sent_i) begin
              state_q <= S_WAIT_RESP;
            end
          end
        end

        // Completion has already been reported, so an abort arriving here is not
        // acted on. This avoids producing a second done pulse.
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_o      = cmd_q;
  assign send_cmd_o = send_cmd_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;
  assign cur_idx_o  = cur_idx_q;

endmodule

// File: tb/tb_cmd_script_seq.sv
// tb_cmd_script_seq: testbench for cmd_script_seq (DEPTH=8, TIMEOUT_CYC=100).
// A table of playback scenarios is applied in a loop. An expected-command queue
// is filled at start and drained on each send_cmd. Hand-written sequences cover
// reset, len=0, exact timeout timing and idle abort handling.
module tb_cmd_script_seq;

  localparam int DEPTH = 8;
  localparam int TOUT  = 100;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  len;
  logic        start;
  logic        abort;
`ifdef SCRIPT_LOOP_EN
  logic        loop;
`endif
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  err_idx;
  logic [2:0]  cur_idx;

  cmd_script_seq #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOUT), .ACK(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .len_i      (len),
    .start_i    (start),
    .abort_i    (abort),
`ifdef SCRIPT_LOOP_EN
    .loop_i     (loop),
`endif
    .cmd_o      (cmd),
    .send_cmd_o (send_cmd),
    .cmd_sent_i (cmd_sent),
    .resp_rdy_i (resp_rdy),
    .resp_i     (resp),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code),
    .err_idx_o  (err_idx),
    .cur_idx_o  (cur_idx)
  );

  typedef struct {
    int         len;
    int         bad;      // entry answered with 0x5A (-1: none)
    int         silent;   // entry never answered (-1: none)
    int         abrt;     // entry aborted together with its response (-1: none)
    bit         disturb;  // wr_en + start while busy
    int         sends;
    bit         err;
    logic [1:0] code;
    int         idx;
    int         cur;
  } vec_t;

  int          n_chk;
  int          n_fail;
  logic [15:0] script [DEPTH];
  logic [15:0] exp_q [$];
  vec_t        vecs [9];
  int          cyc;
  int          sends;
  int          resp_at;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic write_mem(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  n_sent, c, cur, sent_at, r_at;
    bit  got_done;
    n_sent = 0; c = 0; cur = -1; sent_at = -1; r_at = -1; got_done = 1'b0;
    for (int i = 0; i < v.sends; i++) exp_q.push_back(script[i]);
    len = 4'(v.len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy after start", id), 32'(busy), 1);
    while (!got_done && c < 2000) begin
      if (send_cmd) begin
        n_sent++;
        cur = n_sent - 1;
        if (exp_q.size() == 0) chk($sformatf("v%0d unexpected send", id), 32'(n_sent), 32'(v.sends));
        else chk($sformatf("v%0d cmd", id), 32'(cmd), 32'(exp_q.pop_front()));
        sent_at = c + 1;
        r_at = c + 3;
      end
      if (done) got_done = 1'b1;
      cmd_sent = (c == sent_at);
      resp_rdy = 1'b0; abort = 1'b0; resp = 8'h00; wr_en = 1'b0; start = 1'b0;
      if (v.disturb && c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hDEAD; start = 1'b1;
      end
      if (!got_done && c == r_at && cur != v.silent) begin
        resp_rdy = 1'b1;
        resp = (cur == v.bad) ? 8'h5A : 8'hA5;
        if (cur == v.abrt) abort = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    cmd_sent = 1'b0;
    chk($sformatf("v%0d done seen", id), 32'(got_done), 1);
    chk($sformatf("v%0d send count", id), 32'(n_sent), 32'(v.sends));
    chk($sformatf("v%0d err", id), 32'(err), 32'(v.err));
    chk($sformatf("v%0d err_code", id), 32'(err_code), 32'(v.code));
    chk($sformatf("v%0d err_idx", id), 32'(err_idx), 32'(v.idx));
    chk($sformatf("v%0d cur_idx", id), 32'(cur_idx), 32'(v.cur));
    chk($sformatf("v%0d done one cycle", id), 32'(done), 0);
    chk($sformatf("v%0d busy dropped", id), 32'(busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d quiet after done", id), 32'(send_cmd), 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    script = '{16'h2000, 16'h4001, 16'h4012, 16'h4023,
               16'h4104, 16'h4105, 16'h4106, 16'h4107};
    vecs[0] = '{3,  -1, -1, -1, 1'b0, 3, 1'b0, 2'd0, 0, 2};
    vecs[1] = '{3,   1, -1, -1, 1'b0, 2, 1'b1, 2'd2, 1, 1};
    vecs[2] = '{4,  -1, -1,  2, 1'b0, 3, 1'b1, 2'd3, 2, 2};
    vecs[3] = '{8,  -1, -1, -1, 1'b0, 8, 1'b0, 2'd0, 0, 7};
    vecs[4] = '{12, -1, -1, -1, 1'b0, 8, 1'b0, 2'd0, 0, 7};
    vecs[5] = '{1,   0, -1, -1, 1'b0, 1, 1'b1, 2'd2, 0, 0};
    vecs[6] = '{2,  -1,  1, -1, 1'b0, 2, 1'b1, 2'd1, 1, 1};
    vecs[7] = '{2,  -1, -1, -1, 1'b1, 2, 1'b0, 2'd0, 0, 1};
    vecs[8] = '{1,  -1, -1, -1, 1'b0, 1, 1'b0, 2'd0, 0, 0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    start = 1'b0; abort = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
`ifdef SCRIPT_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset cmd", 32'(cmd), 0);
    chk("reset send_cmd", 32'(send_cmd), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    chk("reset err_code", 32'(err_code), 0);
    chk("reset err_idx", 32'(err_idx), 0);
    chk("reset cur_idx", 32'(cur_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) write_mem(i, script[i]);

    // Abort in idle, and start together with abort, both do nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", 32'(busy), 0);
    chk("idle abort err", 32'(err), 0);
    len = 4'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", 32'(busy), 0);
    @(negedge clk);
    chk("start+abort no send", 32'(send_cmd), 0);

    for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

    // len=0: done on the first cycle, with no command sent.
    len = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0 done", 32'(done), 1);
    chk("len0 busy", 32'(busy), 1);
    chk("len0 no send", 32'(send_cmd), 0);
    @(negedge clk);
    chk("len0 done drop", 32'(done), 0);
    chk("len0 busy drop", 32'(busy), 0);
    chk("len0 err", 32'(err), 0);

    // Silent responder: done appears TOUT+1 cycles after the send_cmd pulse.
    len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!send_cmd && cyc < 20) begin @(negedge clk); cyc++; end
    chk("tout send seen", 32'(send_cmd), 1);
    chk("tout cmd", 32'(cmd), 32'(script[0]));
    cyc = 0;
    while (!done && cyc < 300) begin @(negedge clk); cyc++; end
    chk("tout latency", 32'(cyc), 32'(TOUT + 1));
    chk("tout err_code", 32'(err_code), 1);
    chk("tout err_idx", 32'(err_idx), 0);
    repeat (2) @(negedge clk);

    // A response in the same cycle as the timeout limit wins.
    len = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!send_cmd && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (TOUT) @(negedge clk);
    resp_rdy = 1'b1; resp = 8'hA5;
    @(negedge clk);
    resp_rdy = 1'b0;
    chk("limit resp done", 32'(done), 1);
    chk("limit resp err", 32'(err), 0);
    repeat (2) @(negedge clk);

`ifdef SCRIPT_LOOP_EN
    loop = 1'b1; len = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; sends = 0; resp_at = -1;
    while (!done && cyc < 3000) begin
      if (send_cmd) begin
        chk("loop cmd", 32'(cmd), 32'(script[sends % 2]));
        sends++;
        resp_at = cyc + 2;
      end
      resp_rdy = 1'b0; abort = 1'b0;
      if (cyc == resp_at) begin
        if (sends >= 5) abort = 1'b1;
        else begin resp_rdy = 1'b1; resp = 8'hA5; end
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0; resp_rdy = 1'b0; loop = 1'b0;
    chk("loop done", 32'(done), 1);
    chk("loop sends", 32'(sends), 5);
    chk("loop err_code", 32'(err_code), 3);
    chk("loop err_idx", 32'(err_idx), 0);
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_script_seq.md
Name: cmd_script_seq

Overview:
Hardware move-script sequencer. It holds a programmable list of DEPTH 16-bit Knight commands, such as the calibrate command or move commands (fanfare bit, heading, square count). On start it issues them in order to the RemoteComm command interface. For each command it waits for the 8-bit response, checks it against the ACK code and enforces a per-command timeout. It sits between a host/debug register port and RemoteComm, and replaces hand-sequenced command lists with a self-checking, depth-parametrised player.

Parameters:
DEPTH, 8, number of script entries (power of 2, >=2); AW = $clog2(DEPTH)
TIMEOUT_CYC, 10000000, max clk cycles from send_cmd pulse to resp_rdy per command
ACK, 8'hA5, response value counted as success

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  script write strobe (honoured only when busy=0)
wr_addr  in  AW  script entry index
wr_data  in  16  command word
len  in  AW+1  number of entries to play, 0..DEPTH
start  in  1  begin playback at entry 0 (pulse)
abort  in  1  stop playback (pulse)
cmd  out  16  command word to RemoteComm
send_cmd  out  1  one-cycle command strobe to RemoteComm
cmd_sent  in  1  RemoteComm transmit complete
resp_rdy  in  1  RemoteComm response valid (pulse)
resp  in  8  RemoteComm response byte
busy  out  1  playback in progress
done  out  1  one-cycle pulse at normal or error completion
err  out  1  sticky error flag, cleared on next accepted start
err_code  out  2  00 none, 01 timeout, 10 bad response, 11 aborted
err_idx  out  AW  entry index at which the error occurred
cur_idx  out  AW  entry currently being played

Behaviour:
- Reset: state IDLE; cmd=0, send_cmd=0, busy=0, done=0, err=0, err_code=00, err_idx=0, cur_idx=0. Script memory contents are not reset.
- Memory: DEPTH x 16 registers. Write is synchronous on wr_en while busy=0. wr_en while busy=1 is ignored.
- States: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, DONE.
- IDLE:
  - start=1 and abort=0: clear err/err_code/err_idx, set cur_idx=0.
  - If len=0: go to DONE (no command sent).
  - If len>DEPTH: treat as DEPTH.
  - Otherwise go to LOAD. busy rises the cycle after start.
- LOAD: cmd <= mem[cur_idx]; go to SEND.
- SEND: send_cmd=1 for exactly this cycle; timeout counter cleared; go to WAIT_SENT. cmd is held stable from SEND until the response is accepted.
- WAIT_SENT: on cmd_sent go to WAIT_RESP.
- Response handling (WAIT_SENT or WAIT_RESP): resp_rdy in either state is the response; cmd_sent is not required first.
- Response check:
  - resp==ACK: if cur_idx==len-1 go to DONE; else cur_idx++ and go to LOAD.
  - resp!=ACK: err=1, err_code=10, err_idx=cur_idx, go to DONE.
- Timeout: counter runs in WAIT_SENT/WAIT_RESP. On reaching TIMEOUT_CYC without resp_rdy: err=1, err_code=01, err_idx=cur_idx, go to DONE. If resp_rdy arrives in the same cycle as the limit, the response wins.
- Abort: abort in any non-IDLE state goes to DONE with err=1, err_code=11, err_idx=cur_idx. Abort takes priority over resp_rdy and timeout in the same cycle. Abort in IDLE is ignored; start+abort in IDLE starts nothing.
- DONE: done=1 for one cycle, busy=0 the following cycle, return to IDLE. Error fields hold until the next start.
- start while busy: ignored.
- Reset mid-playback: all outputs return to reset values immediately (asynchronous); any partially sent command is abandoned.
- Counter width: $clog2(TIMEOUT_CYC+1); no wrap inside a command.

Optional Feature:
SCRIPT_LOOP_EN
- Defined:
  - Adds input port loop (1).
  - If loop=1 when the last entry is ACKed, cur_idx wraps to 0 and playback continues without asserting done.
  - Exits only via abort (err_code=11) or an error.
  - loop is sampled at each wrap point.
- Undefined: no loop port; playback always ends after len entries.

Test Plan:
- Write {0x2000(cal), 0x4001, 0x4012}, len=3, start; responder returns A5 each -> three send_cmd pulses with cmd 0x2000, 0x4001, 0x4012 in order; one done; err=0; cur_idx=2.
- Same script, responder returns 0x5A on entry 1 -> done after second command; err=1, err_code=10, err_idx=1; third command never sent.
- TIMEOUT_CYC=100, responder silent on entry 0 -> done exactly 100 cycles after the send_cmd pulse (+1 state cycle); err_code=01, err_idx=0.
- Assert abort during WAIT_RESP of entry 2 of a len=4 script with resp_rdy the same cycle -> err_code=11, err_idx=2, no further send_cmd.
- len=0 start -> done pulse after 1 cycle, no send_cmd; wr_en during busy leaves memory unchanged (read back after run); start while busy ignored.
- SCRIPT_LOOP_EN, len=2, loop=1 -> sequence 0,1,0,1,... until abort; done only on abort, err_code=11.
